// File: rtl/wrr_pkg.sv
// Shared types and defaults for the weighted round-robin TX scheduler.
package wrr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int WW_DEF     = 4;
  localparam int WEIGHT_RST = 1;

endpackage

// File: rtl/wrr_rr_pick.sv
// Circular first-set-bit picker: lowest eligible index at or above ptr,
// falling back to the lowest eligible index overall when nothing is above.
module wrr_rr_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   elig,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] idx
);

  logic           m_any;
  logic           u_any;
  logic [IDW-1:0] m_idx;
  logic [IDW-1:0] u_idx;

  // Scan downwards so the lowest matching index is the one left standing.
  always_comb begin
    m_any = 1'b0;
    m_idx = '0;
    u_any = 1'b0;
    u_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (elig[i] && (i >= int'(ptr))) begin
        m_any = 1'b1;
        m_idx = IDW'(i);
      end
      if (elig[i]) begin
        u_any = 1'b1;
        u_idx = IDW'(i);
      end
    end
  end

  assign any = u_any;
  assign idx = m_any ? m_idx : u_idx;

endmodule

// File: rtl/wrr_tx_scheduler.sv
// Weighted round-robin scheduler sharing one TX packet pipeline between N queues.
// Handshake: a grant transfers on a cycle where gnt_valid && gnt_ready; gnt_id/gnt_last hold until then.
module wrr_tx_scheduler
  import wrr_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N),
  parameter int WW  = WW_DEF
) (
  input  logic           clk,
  input  logic           rst_an,
  input  logic           sched_en,
  input  logic [N-1:0]   req,
  input  logic           cfg_we,
  input  logic [IDW-1:0] cfg_idx,
  input  logic [WW-1:0]  cfg_weight,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_last,
  input  logic           gnt_ready,
  output logic           busy
);

  state_e         state;
  state_e         state_n;
  logic [WW-1:0]  weight [N];
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_n;
  logic [IDW-1:0] cur;
  logic [IDW-1:0] cur_n;
  logic [IDW-1:0] cur_inc;
  logic [IDW-1:0] pick_ptr;
  logic [IDW-1:0] pick_idx;
  logic [WW:0]    cnt;
  logic [WW:0]    cnt_n;
  logic [WW:0]    cnt_inc;
  logic [WW:0]    weight_cur;
  logic [N-1:0]   elig;
  logic           pick_any;
  logic           stay;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      elig[i] = req[i] && (weight[i] != '0);
    end
  end

  assign cur_inc    = (int'(cur) == N - 1) ? '0 : cur + 1'b1;
  assign cnt_inc    = cnt + 1'b1;
  assign weight_cur = {1'b0, weight[cur]};
  assign stay       = sched_en && req[cur] && (cnt < weight_cur);
  // A turn ending in GAP searches from the slot after cur, not the stale ptr.
  assign pick_ptr   = (state == GAP) ? cur_inc : ptr;

  wrr_rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .elig (elig),
    .ptr  (pick_ptr),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      for (int i = 0; i < N; i++) begin
        weight[i] <= WW'(WEIGHT_RST);
      end
    end else if (cfg_we && (int'(cfg_idx) < N)) begin
      weight[cfg_idx] <= cfg_weight;
    end
  end

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      state <= IDLE;
      ptr   <= '0;
      cur   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      cur   <= cur_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cur_n   = cur;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (sched_en && pick_any) begin
          cur_n   = pick_idx;
          cnt_n   = '0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (gnt_ready) begin
          cnt_n   = cnt_inc;
          state_n = GAP;
        end
      end
      GAP: begin
        if (stay) begin
          state_n = GRANT;
        end else begin
          ptr_n = cur_inc;
          if (sched_en && pick_any) begin
            cur_n   = pick_idx;
            cnt_n   = '0;
            state_n = GRANT;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign gnt_valid = (state == GRANT);
  assign gnt_id    = cur;
  assign gnt_last  = (state == GRANT) && (cnt_inc >= weight_cur);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_wrr_tx_scheduler.sv
// Self-checking bench for wrr_tx_scheduler: directed scenarios plus a randomized
// run compared against a grant-level weighted round-robin reference model.
module tb_wrr_tx_scheduler;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_an;
  logic       sched_en;
  logic [3:0] req;
  logic       cfg_we;
  logic [1:0] cfg_idx;
  logic [3:0] cfg_weight;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       gnt_last;
  logic       gnt_ready;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Reference model: per-queue quantum, turn pointer, current turn owner and grants used.
  int m_w [N];
  int m_ptr;
  int m_cur;
  int m_cnt;
  bit m_in_turn;

  wrr_tx_scheduler #(.N(4), .IDW(2), .WW(4)) dut (
    .clk        (clk),
    .rst_an     (rst_an),
    .sched_en   (sched_en),
    .req        (req),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_weight (cfg_weight),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id),
    .gnt_last   (gnt_last),
    .gnt_ready  (gnt_ready),
    .busy       (busy)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_w[i] = 1;
    m_ptr = 0; m_cur = 0; m_cnt = 0; m_in_turn = 0;
  endfunction

  // Next grant given the request vector seen when the scheduler decided.
  function automatic void model_next(input logic [3:0] r, output int id, output bit last);
    if (!(m_in_turn && r[m_cur] && (m_cnt < m_w[m_cur]))) begin
      if (m_in_turn) m_ptr = (m_cur + 1) % N;
      id = -1;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (id < 0 && r[j] && m_w[j] != 0) id = j;
      end
      m_cur = id; m_cnt = 0; m_in_turn = 1;
    end
    m_cnt++;
    id   = m_cur;
    last = (m_cnt >= m_w[m_cur]);
  endfunction

  function automatic void model_idle();
    if (m_in_turn) m_ptr = (m_cur + 1) % N;
    m_in_turn = 0;
  endfunction

  function automatic logic [3:0] rand_req();
    logic [3:0] r;
    int s;
    r = 4'($urandom_range(0, 15));
    s = $urandom_range(0, N - 1);
    for (int k = 0; k < N; k++) begin
      if (m_w[(s + k) % N] != 0) begin
        r[(s + k) % N] = 1'b1;
        break;
      end
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_an = 1'b0; sched_en = 1'b1; req = '0; cfg_we = 1'b0;
    cfg_idx = '0; cfg_weight = '0; gnt_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_an = 1'b1;
    model_reset();
  endtask

  task automatic cfg_write(input int idx, input int w);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_weight = 4'(w);
    @(negedge clk);
    cfg_we = 1'b0;
    m_w[idx] = w;
  endtask

  task automatic drain();
    req = '0; gnt_ready = 1'b1;
    repeat (4) @(negedge clk);
    gnt_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (gnt_valid !== 1'b0 || gnt_id !== 2'd0 || gnt_last !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: valid=%b id=%0d last=%b busy=%b, expected 0 0 0 0",
               gnt_valid, gnt_id, gnt_last, busy);
    end
  endtask

  task automatic test_equal_weights();
    int exp_id [5] = '{0, 1, 2, 3, 0};
    int seen = 0;
    int last_t = -1;
    do_reset();
    req = 4'b1111; gnt_ready = 1'b1;
    for (int t = 0; t < 40 && seen < 5; t++) begin
      @(negedge clk);
      if (gnt_valid) begin
        checks++;
        if (gnt_id !== 2'(exp_id[seen]) || gnt_last !== 1'b1) begin
          errors++;
          $display("FAIL equal_weights grant %0d: id=%0d last=%b, expected id=%0d last=1",
                   seen, gnt_id, gnt_last, exp_id[seen]);
        end
        checks++;
        if ((seen == 0 && t != 0) || (seen != 0 && t - last_t != 2)) begin
          errors++;
          $display("FAIL equal_weights timing grant %0d: cycle=%0d prev=%0d, expected %0d",
                   seen, t, last_t, (seen == 0) ? 0 : last_t + 2);
        end
        last_t = t;
        seen++;
      end
    end
    checks++;
    if (seen != 5) begin
      errors++;
      $display("FAIL equal_weights count: got %0d grants, expected 5", seen);
    end
    drain();
  endtask

  task automatic test_weighted();
    int exp_id [8]  = '{0, 0, 0, 1, 0, 0, 0, 1};
    bit exp_lst [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
    int seen = 0;
    do_reset();
    cfg_write(0, 3);
    req = 4'b0011; gnt_ready = 1'b1;
    for (int t = 0; t < 60 && seen < 8; t++) begin
      @(negedge clk);
      if (gnt_valid) begin
        checks++;
        if (gnt_id !== 2'(exp_id[seen]) || gnt_last !== exp_lst[seen]) begin
          errors++;
          $display("FAIL weighted grant %0d: id=%0d last=%b, expected id=%0d last=%b",
                   seen, gnt_id, gnt_last, exp_id[seen], exp_lst[seen]);
        end
        seen++;
      end
    end
    checks++;
    if (seen != 8) begin
      errors++;
      $display("FAIL weighted count: got %0d grants, expected 8", seen);
    end
    drain();
  endtask

  task automatic test_weight_zero();
    int exp_id [9]  = '{2, 2, 2, 1, 1, 2, 1, 1, 2};
    bit exp_lst [9] = '{1, 1, 1, 0, 1, 1, 0, 1, 1};
    int seen = 0;
    do_reset();
    cfg_write(1, 0);
    req = 4'b0110; gnt_ready = 1'b1;
    for (int t = 0; t < 80 && seen < 9; t++) begin
      @(negedge clk);
      cfg_we = 1'b0;
      if (gnt_valid) begin
        checks++;
        if (gnt_id !== 2'(exp_id[seen]) || gnt_last !== exp_lst[seen]) begin
          errors++;
          $display("FAIL weight_zero grant %0d: id=%0d last=%b, expected id=%0d last=%b",
                   seen, gnt_id, gnt_last, exp_id[seen], exp_lst[seen]);
        end
        if (seen == 2) begin
          cfg_we = 1'b1; cfg_idx = 2'd1; cfg_weight = 4'd2;
        end
        seen++;
      end
    end
    cfg_we = 1'b0;
    checks++;
    if (seen != 9) begin
      errors++;
      $display("FAIL weight_zero count: got %0d grants, expected 9", seen);
    end
    drain();
  endtask

  task automatic test_back_pressure();
    do_reset();
    req = 4'b0100; gnt_ready = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (gnt_valid !== 1'b1 || gnt_id !== 2'd2) begin
        errors++;
        $display("FAIL back_pressure hold cycle %0d: valid=%b id=%0d, expected 1 2",
                 k, gnt_valid, gnt_id);
      end
      if (k == 2) sched_en = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (gnt_valid !== 1'b1 || gnt_id !== 2'd2) begin
      errors++;
      $display("FAIL back_pressure after disable: valid=%b id=%0d, expected 1 2", gnt_valid, gnt_id);
    end
    gnt_ready = 1'b1;
    @(negedge clk);
    gnt_ready = 1'b0;
    checks++;
    if (gnt_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL back_pressure gap: valid=%b busy=%b, expected 0 1", gnt_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (gnt_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL back_pressure idle: valid=%b busy=%b, expected 0 0", gnt_valid, busy);
    end
    req = '0; sched_en = 1'b1;
  endtask

  task automatic test_req_drop();
    do_reset();
    cfg_write(0, 3);
    req = 4'b1001; gnt_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt_valid !== 1'b1 || gnt_id !== 2'd0 || gnt_last !== 1'b0) begin
      errors++;
      $display("FAIL req_drop first: valid=%b id=%0d last=%b, expected 1 0 0", gnt_valid, gnt_id, gnt_last);
    end
    @(negedge clk);
    checks++;
    if (gnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL req_drop gap: valid=%b, expected 0", gnt_valid);
    end
    req = 4'b1000;
    @(negedge clk);
    checks++;
    if (gnt_valid !== 1'b1 || gnt_id !== 2'd3 || gnt_last !== 1'b1) begin
      errors++;
      $display("FAIL req_drop next turn: valid=%b id=%0d last=%b, expected 1 3 1", gnt_valid, gnt_id, gnt_last);
    end
    @(negedge clk);
    req = 4'b1001;
    @(negedge clk);
    checks++;
    if (gnt_valid !== 1'b1 || gnt_id !== 2'd0 || gnt_last !== 1'b0) begin
      errors++;
      $display("FAIL req_drop wrap: valid=%b id=%0d last=%b, expected 1 0 0", gnt_valid, gnt_id, gnt_last);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    do_reset();
    cfg_write(1, 3);
    req = 4'b0110; gnt_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt_valid !== 1'b1 || gnt_id !== 2'd1 || gnt_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid before: valid=%b id=%0d last=%b, expected 1 1 0", gnt_valid, gnt_id, gnt_last);
    end
    rst_an = 1'b0;
    #1;
    checks++;
    if (gnt_valid !== 1'b0 || busy !== 1'b0 || gnt_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid async: valid=%b busy=%b last=%b, expected 0 0 0", gnt_valid, busy, gnt_last);
    end
    @(negedge clk);
    rst_an = 1'b1;
    model_reset();
    @(negedge clk);
    checks++;
    if (gnt_valid !== 1'b1 || gnt_id !== 2'd1 || gnt_last !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid after: valid=%b id=%0d last=%b, expected 1 1 1", gnt_valid, gnt_id, gnt_last);
    end
    drain();
  endtask

  task automatic test_random();
    logic [3:0] req_dec;
    int  exp_id;
    bit  exp_last;
    bit  have_exp;
    int  grants;
    bit  drained;
    do_reset();
    req_dec = '0;
    for (int r = 0; r < 6; r++) begin
      int q;
      for (int i = 0; i < N; i++) cfg_write(i, $urandom_range(0, 3));
      q = $urandom_range(0, N - 1);
      if (m_w[q] == 0) cfg_write(q, $urandom_range(1, 3));
      have_exp = 0;
      grants = 0;
      for (int cyc = 0; cyc < 150; cyc++) begin
        @(negedge clk);
        if (gnt_valid) begin
          if (!have_exp) begin
            model_next(req_dec, exp_id, exp_last);
            have_exp = 1;
          end
          checks++;
          if (gnt_id !== 2'(exp_id) || gnt_last !== exp_last) begin
            errors++;
            $display("FAIL random round %0d cycle %0d: id=%0d last=%b, expected id=%0d last=%b",
                     r, cyc, gnt_id, gnt_last, exp_id, exp_last);
          end
          gnt_ready = ($urandom_range(0, 3) != 0);
          if (gnt_ready) begin
            have_exp = 0;
            grants++;
          end
        end else begin
          req = rand_req();
          req_dec = req;
        end
      end
      drained = 0;
      for (int k = 0; k < 20 && !drained; k++) begin
        @(negedge clk);
        if (gnt_valid) begin
          if (!have_exp) model_next(req_dec, exp_id, exp_last);
          checks++;
          if (gnt_id !== 2'(exp_id) || gnt_last !== exp_last) begin
            errors++;
            $display("FAIL random drain round %0d: id=%0d last=%b, expected id=%0d last=%b",
                     r, gnt_id, gnt_last, exp_id, exp_last);
          end
          gnt_ready = 1'b1;
          have_exp = 0;
        end else begin
          req = '0;
          drained = 1;
        end
      end
      repeat (2) @(negedge clk);
      gnt_ready = 1'b0;
      model_idle();
      checks++;
      if (busy !== 1'b0 || grants == 0 || !drained) begin
        errors++;
        $display("FAIL random round %0d end: busy=%b grants=%0d drained=%b, expected busy=0 grants>0 drained=1",
                 r, busy, grants, drained);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_equal_weights();
    test_weighted();
    test_weight_zero();
    test_back_pressure();
    test_req_drop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wrr_tx_scheduler.md
Name: wrr_tx_scheduler

Overview:
- Weighted round-robin scheduler that shares the single TX packet pipeline between N send queues (QPs) for per-QP bandwidth isolation.
- Each queue may win up to WEIGHT[i] consecutive packet grants per turn (its quantum) before the turn passes to the next eligible queue in circular order.
- Grants go downstream on a valid/ready handshake, one packet per grant.
- Weights are written at runtime through a simple config port.

Parameters:
- N, 4, number of requesting queues (N >= 2).
- IDW, $clog2(N), width of gnt_id.
- WW, 4, weight width; quantum range 0..2^WW-1.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_an  in  1  asynchronous active-low reset.
- sched_en  in  1  enables issue of new turns and grants.
- req  in  N  req[i]=1: queue i has at least one packet ready. Level signal. Must not drop while gnt_valid is high with gnt_id==i.
- cfg_we  in  1  weight write strobe.
- cfg_idx  in  IDW  queue index for cfg write.
- cfg_weight  in  WW  new quantum; 0 disables the queue.
- gnt_valid  out  1  grant offered.
- gnt_id  out  IDW  granted queue index.
- gnt_last  out  1  this grant exhausts the quantum of gnt_id.
- gnt_ready  in  1  downstream accepts the grant.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values:
  - gnt_valid=0, gnt_id=0, gnt_last=0, busy=0.
  - All weights=1, ptr=0, cnt=0, cur=0, state=IDLE.
- Eligible vector: elig = req & {weight[i]!=0}.
- Pick: first set bit of elig at index >= ptr, else first set bit from index 0 (wrap). Implemented as a masked/unmasked priority pair.
- States and transitions:
  - IDLE: if sched_en && |elig: cur<=pick, cnt<=0, go to GRANT.
  - GRANT:
    - gnt_valid=1, gnt_id=cur, gnt_last=(cnt+1 >= weight[cur]).
    - gnt_valid and gnt_id stay stable until gnt_ready.
    - On handshake: cnt<=cnt+1, go to GAP.
  - GAP (one cycle, gnt_valid=0; lets the requester update req):
    - If sched_en && req[cur] && cnt < weight[cur]: stay on cur, go to GRANT.
    - Else the turn ends: ptr<=(cur+1) mod N.
      - If sched_en && |elig: cur<=pick using the new pointer (computed combinationally from cur+1 in the same cycle), cnt<=0, go to GRANT.
      - Otherwise go to IDLE.
- Latency and throughput:
  - Req to first gnt_valid: 1 cycle from IDLE (req sampled at edge t, gnt_valid high at t+1).
  - Peak throughput: one grant per 2 cycles.
- Config writes:
  - Take effect the cycle after cfg_we.
  - A write to cur during GRANT does not alter the outstanding grant; the new weight is used at the next GAP decision and in gnt_last from the next cycle.
  - Weight 0 on cur ends the turn at the next GAP.
- sched_en=0 while in GRANT: the outstanding grant still completes; GAP then goes to IDLE.
- Single eligible queue: after its quantum is exhausted, a new turn re-selects the same queue with cnt=0. No idle bubble beyond GAP.
- Reset asserted mid-grant: all state returns to reset values immediately; gnt_valid drops asynchronously.
- cnt width is WW+1; no overflow possible since cnt <= 2^WW-1.

Decomposition:
- Package wrr_pkg:
  - State enum (IDLE, GRANT, GAP).
  - Default WW.
  - WEIGHT_RST=1.
- Sub-module wrr_rr_pick (combinational):
  - Inputs: elig[N], ptr[IDW].
  - Outputs: any, idx[IDW].
  - Built as masked-priority plus unmasked-priority fallback.

Test Plan:
- Reset, weights all 1, req=4'b1111, gnt_ready=1 → gnt_id sequence 0,1,2,3,0, each with gnt_last=1, one grant every 2 cycles.
- weights={3,1,1,1} (w0=3), req=4'b0011 constant, ready=1 → ids 0,0,0,1,0,0,0,1. gnt_last=1 only on the third 0 and on each 1.
- w1=0, req=4'b0110 → only id 2 ever granted; write w1=2 mid-stream → from the next turn the sequence is 1,1,2,1,1,2.
- gnt_ready held 0 for 5 cycles with gnt_id=2 → gnt_valid and gnt_id stable for all 5 cycles. Asserting sched_en=0 during that time still completes the grant, then busy=0 after GAP.
- req[0] drops in GAP after 1 of 3 grants with req=4'b1001 → turn ends early, next gnt_id=3, ptr then wraps to 0.
- rst_an pulsed low while gnt_valid=1 → gnt_valid=0 immediately. After release, weights=1 and the first grant goes to the lowest requesting index.
